// File: rtl/ring_pkg.sv
// Shared field layout, port indices and small helpers for the bidirectional ring router.
// Packet: [63] vc, [62] dir (0=cw, 1=ccw), [61:56] reserved, [55:48] hop, [47:0] payload.
package ring_pkg;

  localparam int DATA_W  = 64;
  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;

  localparam int NPORT = 3;
  localparam int NVC   = 2;

  localparam int P_CW  = 0;
  localparam int P_CCW = 1;
  localparam int P_PE  = 2;

  typedef logic [DATA_W-1:0] pkt_t;

  // Each output has a "ring" contender (favoured after reset) and an alternate contender.
  function automatic int ring_src(input int out_port);
    return (out_port == P_CCW) ? P_CCW : P_CW;
  endfunction

  function automatic int alt_src(input int out_port);
    return (out_port == P_PE) ? P_CCW : P_PE;
  endfunction

  function automatic pkt_t hop_dec(input pkt_t p);
    pkt_t r;
    r = p;
    r[HOP_MSB:HOP_LSB] = p[HOP_MSB:HOP_LSB] - 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/ring_node_router_if.sv
// One unidirectional link: send (s), ready (r), data (d).
// master drives s/d and samples r; slave samples s/d and drives r.
interface ring_node_router_if;
  import ring_pkg::*;

  logic        s;
  logic        r;
  logic [DATA_W-1:0] d;

  modport master (output s, output d, input r);
  modport slave  (input s, input d, output r);

endinterface

// File: rtl/vc_buffer.sv
// Single-entry packet register with full flag; load wins over clear (never both by construction).
// One-cycle load-to-visible latency; no internal backpressure, the owner checks full_o.
module vc_buffer
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              full_o,
  output logic [DATA_W-1:0] dat_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] dat_q,  dat_d;

  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (load_i) begin
      full_d = 1'b1;
      dat_d  = dat_i;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end

  assign full_o = full_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/ring_node_router.sv
// Two-VC ring node: links move vc==polarity packets, the crossbar moves vc==~polarity packets.
// Eject latency two cycles (link -> input buffer -> output buffer); blocked packets wait in place.
module ring_node_router
  import ring_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  ring_node_router_if.slave   cwi,
  ring_node_router_if.master  cwo,
  ring_node_router_if.slave   ccwi,
  ring_node_router_if.master  ccwo,
  ring_node_router_if.slave   pei,
  ring_node_router_if.master  peo,
  output logic                polarity
);

  logic polarity_q, polarity_d;
  logic fv;

  logic [NPORT-1:0]          in_s, in_r, out_s, out_ro;
  logic [DATA_W-1:0]         in_d  [NPORT];
  logic [DATA_W-1:0]         out_d [NPORT];

  logic [NPORT-1:0][NVC-1:0] in_full, in_load, in_clr;
  logic [NPORT-1:0][NVC-1:0] out_full, out_load, out_clr;
  logic [NPORT-1:0][NVC-1:0] rr_q, rr_d;
  logic [DATA_W-1:0]         in_dat  [NPORT][NVC];
  logic [DATA_W-1:0]         out_dat [NPORT][NVC];

  logic [NPORT-1:0]          fwd_req;
  logic [1:0]                fwd_tgt     [NPORT];
  logic [DATA_W-1:0]         fwd_pkt     [NPORT];
  logic [DATA_W-1:0]         out_fwd_dat [NPORT];

  assign in_s[P_CW]   = cwi.s;
  assign in_s[P_CCW]  = ccwi.s;
  assign in_s[P_PE]   = pei.s;
  assign in_d[P_CW]   = cwi.d;
  assign in_d[P_CCW]  = ccwi.d;
  assign in_d[P_PE]   = pei.d;
  assign cwi.r        = in_r[P_CW];
  assign ccwi.r       = in_r[P_CCW];
  assign pei.r        = in_r[P_PE];

  assign cwo.s        = out_s[P_CW];
  assign ccwo.s       = out_s[P_CCW];
  assign peo.s        = out_s[P_PE];
  assign cwo.d        = out_d[P_CW];
  assign ccwo.d       = out_d[P_CCW];
  assign peo.d        = out_d[P_PE];
  assign out_ro[P_CW]  = cwo.r;
  assign out_ro[P_CCW] = ccwo.r;
  assign out_ro[P_PE]  = peo.r;

  assign polarity   = polarity_q;
  assign polarity_d = ~polarity_q;
  assign fv         = ~polarity_q;

  // An arrival is only stored into an empty slot, so a protocol error can never clobber a packet.
  always_comb begin : in_accept_c
    for (int p = 0; p < NPORT; p++) begin
      in_r[p] = ~in_full[p][polarity_q];
      for (int v = 0; v < NVC; v++) begin
        in_load[p][v] = in_s[p] && !in_full[p][polarity_q] &&
                        (in_d[p][VC_BIT] == 1'(v)) && !in_full[p][v];
      end
    end
  end

  always_comb begin : route_c
    logic [DATA_W-1:0] pkt;
    pkt = '0;
    for (int p = 0; p < NPORT; p++) begin
      pkt         = in_dat[p][fv];
      fwd_req[p]  = in_full[p][fv];
      fwd_pkt[p]  = pkt;
      fwd_tgt[p]  = 2'(P_PE);
      if (p == P_PE) begin
        fwd_tgt[p] = pkt[DIR_BIT] ? 2'(P_CCW) : 2'(P_CW);
      end else if (pkt[HOP_MSB:HOP_LSB] != 8'd0) begin
        fwd_tgt[p] = 2'(p);
        fwd_pkt[p] = hop_dec(pkt);
      end
    end
  end

  // Round-robin pointer: 0 favours the ring contender, toggled only when both contenders request.
  always_comb begin : arb_c
    int   a, b;
    logic req_a, req_b, can, gnt_a, gnt_b;
    in_clr   = '0;
    out_load = '0;
    rr_d     = rr_q;
    a = 0; b = 0;
    req_a = 1'b0; req_b = 1'b0; can = 1'b0; gnt_a = 1'b0; gnt_b = 1'b0;
    for (int o = 0; o < NPORT; o++) begin
      a     = ring_src(o);
      b     = alt_src(o);
      req_a = fwd_req[a] && (fwd_tgt[a] == 2'(o));
      req_b = fwd_req[b] && (fwd_tgt[b] == 2'(o));
      can   = !out_full[o][fv];
      gnt_a = can && req_a && (!req_b || !rr_q[o][fv]);
      gnt_b = can && req_b && (!req_a ||  rr_q[o][fv]);
      if (can && req_a && req_b) begin
        rr_d[o][fv] = ~rr_q[o][fv];
      end
      if (gnt_a) begin
        in_clr[a][fv] = 1'b1;
      end
      if (gnt_b) begin
        in_clr[b][fv] = 1'b1;
      end
      out_load[o][fv] = gnt_a || gnt_b;
      out_fwd_dat[o]  = gnt_a ? fwd_pkt[a] : fwd_pkt[b];
    end
  end

  always_comb begin : out_drain_c
    for (int o = 0; o < NPORT; o++) begin
      out_s[o] = out_full[o][polarity_q] && out_ro[o];
      out_d[o] = out_dat[o][polarity_q];
      for (int v = 0; v < NVC; v++) begin
        out_clr[o][v] = out_s[o] && (polarity_q == 1'(v));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_q <= 1'b0;
      rr_q       <= '0;
    end else begin
      polarity_q <= polarity_d;
      rr_q       <= rr_d;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    for (genvar v = 0; v < NVC; v++) begin : g_vc
      vc_buffer u_in_buf (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (in_load[p][v]),
        .clear_i (in_clr[p][v]),
        .dat_i   (in_d[p]),
        .full_o  (in_full[p][v]),
        .dat_o   (in_dat[p][v])
      );
      vc_buffer u_out_buf (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (out_load[p][v]),
        .clear_i (out_clr[p][v]),
        .dat_i   (out_fwd_dat[p]),
        .full_o  (out_full[p][v]),
        .dat_o   (out_dat[p][v])
      );
    end
  end

endmodule

// File: tb/tb_ring_node_router.sv
// Directed bench for ring_node_router: reset, eject, forward, inject/backpressure, contention, reset discard.
module tb_ring_node_router;

  logic clk;
  logic rst_n;
  logic polarity;

  int vec_cnt;
  int err_cnt;

  ring_node_router_if cwi ();
  ring_node_router_if cwo ();
  ring_node_router_if ccwi ();
  ring_node_router_if ccwo ();
  ring_node_router_if pei ();
  ring_node_router_if peo ();

  ring_node_router dut (
    .clk      (clk),
    .reset    (rst_n),
    .cwi      (cwi),
    .cwo      (cwo),
    .ccwi     (ccwi),
    .ccwo     (ccwo),
    .pei      (pei),
    .peo      (peo),
    .polarity (polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] pk(input logic vc, input logic dir, input logic [5:0] rs,
                                     input logic [7:0] hop, input logic [47:0] pl);
    return {vc, dir, rs, hop, pl};
  endfunction

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    cwi.s = 1'b0; ccwi.s = 1'b0; pei.s = 1'b0;
    cwi.d = '0;   ccwi.d = '0;   pei.d = '0;
    cwo.r = 1'b1; ccwo.r = 1'b1; peo.r = 1'b1;

    // reset held with random link activity
    for (int i = 0; i < 3; i++) begin
      cwi.s  = 1'($urandom); ccwi.s = 1'($urandom); pei.s = 1'($urandom);
      cwi.d  = {$urandom, $urandom}; ccwi.d = {$urandom, $urandom}; pei.d = {$urandom, $urandom};
      cwo.r  = 1'($urandom); ccwo.r = 1'($urandom); peo.r = 1'($urandom);
      #1;
      chk("rst_so", {cwo.s, ccwo.s, peo.s}, 3'b000);
      chk("rst_ri", {cwi.r, ccwi.r, pei.r}, 3'b111);
      chk("rst_pol", polarity, 1'b0);
      chk("rst_do", cwo.d | ccwo.d | peo.d, 64'h0);
      step();
    end
    cwi.s = 1'b0; ccwi.s = 1'b0; pei.s = 1'b0;
    cwo.r = 1'b1; ccwo.r = 1'b1; peo.r = 1'b1;
    rst_n = 1'b1;
    #1 chk("rel_pol0", polarity, 1'b0);
    step(); chk("rel_pol1", polarity, 1'b1);
    step(); chk("rel_pol2", polarity, 1'b0);

    // eject: cw ring packet with hop 0 reaches the NIC two cycles later
    cwi.d = pk(1'b0, 1'b0, 6'h0, 8'h00, 48'hA5);
    cwi.s = 1'b1;
    #1 chk("ej_ri", cwi.r, 1'b1);
    step(); cwi.s = 1'b0;
    chk("ej_early", peo.s, 1'b0);
    step();
    chk("ej_so", peo.s, 1'b1);
    chk("ej_do", peo.d, pk(1'b0, 1'b0, 6'h0, 8'h00, 48'hA5));
    chk("ej_pol", polarity, 1'b0);
    step(); chk("ej_gone1", peo.s, 1'b0);
    step(); chk("ej_gone2", peo.s, 1'b0);

    // forward: ccw vc1 hop 3 leaves ccw with hop 2 in a polarity=1 cycle
    step();
    ccwi.d = pk(1'b1, 1'b1, 6'h2A, 8'd3, 48'h1234_5678_9ABC);
    ccwi.s = 1'b1;
    step(); ccwi.s = 1'b0;
    chk("fw_early", ccwo.s, 1'b0);
    step();
    chk("fw_so", ccwo.s, 1'b1);
    chk("fw_do", ccwo.d, pk(1'b1, 1'b1, 6'h2A, 8'd2, 48'h1234_5678_9ABC));
    chk("fw_pol", polarity, 1'b1);
    step(); chk("fw_gone", ccwo.s, 1'b0);

    // inject with cw link stalled until both vc0 buffers fill
    cwo.r = 1'b0;
    pei.d = pk(1'b0, 1'b0, 6'h0, 8'd5, 48'h111);
    pei.s = 1'b1;
    #1 chk("inj_ri0", pei.r, 1'b1);
    step(); pei.s = 1'b0;
    step();
    chk("inj_stall", cwo.s, 1'b0);
    chk("inj_ri1", pei.r, 1'b1);
    pei.d = pk(1'b0, 1'b0, 6'h0, 8'd5, 48'h222);
    pei.s = 1'b1;
    step(); pei.s = 1'b0;
    step();
    chk("inj_ri_full", pei.r, 1'b0);
    chk("inj_stall2", cwo.s, 1'b0);
    pei.d = pk(1'b0, 1'b0, 6'h0, 8'd5, 48'h333);
    pei.s = 1'b1;
    cwo.r = 1'b1;
    #1;
    chk("inj_so1", cwo.s, 1'b1);
    chk("inj_do1", cwo.d, pk(1'b0, 1'b0, 6'h0, 8'd5, 48'h111));
    step(); pei.s = 1'b0;
    chk("inj_vc1_idle", cwo.s, 1'b0);
    step();
    chk("inj_ri_back", pei.r, 1'b1);
    chk("inj_so2", cwo.s, 1'b1);
    chk("inj_do2", cwo.d, pk(1'b0, 1'b0, 6'h0, 8'd5, 48'h222));
    step(); chk("inj_idle1", cwo.s, 1'b0);
    step(); chk("inj_no_err_pkt", cwo.s, 1'b0);

    // contention for cw output vc0, twice, winner alternates
    for (int r = 0; r < 2; r++) begin
      cwi.d = pk(1'b0, 1'b0, 6'h0, 8'd1, 48'hC0 + 48'(r));
      pei.d = pk(1'b0, 1'b0, 6'h0, 8'd7, 48'hE0 + 48'(r));
      cwi.s = 1'b1; pei.s = 1'b1;
      step(); cwi.s = 1'b0; pei.s = 1'b0;
      step();
      chk("ct_so_a", cwo.s, 1'b1);
      chk("ct_first", cwo.d, (r == 0) ? pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hC0)
                                      : pk(1'b0, 1'b0, 6'h0, 8'd7, 48'hE1));
      step(); step();
      chk("ct_so_b", cwo.s, 1'b1);
      chk("ct_second", cwo.d, (r == 0) ? pk(1'b0, 1'b0, 6'h0, 8'd7, 48'hE0)
                                       : pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hC1));
      step(); step();
    end

    // eject backpressure: four packets parked, then drained in arbitration order
    peo.r  = 1'b0;
    cwi.d  = pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hB1);
    ccwi.d = pk(1'b0, 1'b1, 6'h0, 8'd0, 48'hB2);
    cwi.s = 1'b1; ccwi.s = 1'b1;
    step();
    cwi.d  = pk(1'b1, 1'b0, 6'h0, 8'd0, 48'hB3);
    ccwi.d = pk(1'b1, 1'b1, 6'h0, 8'd0, 48'hB4);
    step(); cwi.s = 1'b0; ccwi.s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", peo.s, 1'b0);
      step();
    end
    chk("bp_ccw_ri", ccwi.r, 1'b0);
    chk("bp_cw_ri", cwi.r, 1'b1);
    peo.r = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (peo.s) got_q.push_back(peo.d);
      step();
    end
    exp_q.push_back(pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hB1));
    exp_q.push_back(pk(1'b1, 1'b0, 6'h0, 8'd0, 48'hB3));
    exp_q.push_back(pk(1'b0, 1'b1, 6'h0, 8'd0, 48'hB2));
    exp_q.push_back(pk(1'b1, 1'b1, 6'h0, 8'd0, 48'hB4));
    chk("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", (i < got_q.size()) ? got_q[i] : 64'hX, exp_q[i]);
    end

    // reset mid-flight discards the packet
    cwi.d = pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hDD);
    cwi.s = 1'b1;
    step(); cwi.s = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_pol", polarity, 1'b0);
    chk("mr_ri", cwi.r, 1'b1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_discard", peo.s, 1'b0);
    end

    // first transfer on the first edge after release
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cwi.d = pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hEE);
    cwi.s = 1'b1;
    #1 chk("fr_ri", cwi.r, 1'b1);
    step(); cwi.s = 1'b0;
    step();
    chk("fr_so", peo.s, 1'b1);
    chk("fr_do", peo.d, pk(1'b0, 1'b0, 6'h0, 8'd0, 48'hEE));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
